// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with write-port bypass and load-use scoreboard
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int MAX_PEND = 4,
    localparam int AW      = $clog2(NREGS),
    localparam int CW      = $clog2(MAX_PEND + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wa_en,
    input  logic [AW-1:0]       wa_addr,
    input  logic [XLEN-1:0]     wa_data,
    input  logic                wl_en,
    input  logic [AW-1:0]       wl_addr,
    input  logic [XLEN-1:0]     wl_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic                iss_is_load,
    output logic                iss_ready,
    input  logic                flush,
    output logic [CW-1:0]       pend_cnt
);
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] sb, sb_n;
    logic [CW-1:0]    cnt_n;
    logic [CW:0]      up, dn, net;
    logic             load_iss, wl_clr, waw, waw_dec;

    assign iss_ready = pend_cnt < CW'(MAX_PEND);

    // next scoreboard and count: wl/WAW clears, then load set wins, flush overrides all
    always_comb begin
        load_iss = iss_valid & iss_ready & iss_is_load & (iss_rd != '0);
        wl_clr   = wl_en & sb[wl_addr];
        waw      = iss_valid & ~iss_is_load & sb[iss_rd];
        waw_dec  = waw & ~(wl_clr & (wl_addr == iss_rd));
        sb_n     = sb;
        if (wl_en) sb_n[wl_addr] = 1'b0;
        if (waw) sb_n[iss_rd] = 1'b0;
        if (load_iss) sb_n[iss_rd] = 1'b1;
        if (flush) sb_n = '0;
        up    = {1'b0, pend_cnt} + (CW+1)'(load_iss);
        dn    = (CW+1)'(wl_clr) + (CW+1)'(waw_dec);
        net   = up - dn;
        cnt_n = (flush || up < dn) ? '0 : (net > (CW+1)'(MAX_PEND)) ? CW'(MAX_PEND) : net[CW-1:0];
    end

    // scoreboard and pending-load count state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb       <= '0;
            pend_cnt <= '0;
        end else begin
            sb       <= sb_n;
            pend_cnt <= cnt_n;
        end
    end

    // register array writes; port L is applied last so it wins a same-address conflict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) regs[k] <= '0;
        end else begin
            if (wa_en && wa_addr != '0) regs[wa_addr] <= wa_data;
            if (wl_en && wl_addr != '0) regs[wl_addr] <= wl_data;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        assign a = rd_addr[i*AW +: AW];
        assign rd_data[i*XLEN +: XLEN] = (!rst_n || a == '0) ? '0 :
                                         (wl_en && wl_addr == a) ? wl_data :
                                         (wa_en && wa_addr == a) ? wa_data : regs[a];
        assign rd_busy[i] = sb[a] & ~(wl_en && wl_addr == a);
    end
endmodule
